// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles the command handshake, the ALU drive/return path and the result
//   handshake of alu_op_sequencer.
//   slave  : sequencer side (takes commands, drives the ALU, returns results)
//   master : environment side (issues commands, models the ALU, consumes results)
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_imm_en;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_ra;
  logic [2:0]  cmd_rb;
  logic [31:0] cmd_imm;

  logic [2:0]  alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic        res_zero;

  modport slave (
    input  cmd_valid, cmd_imm_en, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  alu_out, res_ready,
    output cmd_ready, alu_sel, alu_a, alu_b,
    output res_valid, res_data, res_rd, res_zero
  );

  modport master (
    output cmd_valid, cmd_imm_en, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output alu_out, res_ready,
    input  cmd_ready, alu_sel, alu_a, alu_b,
    input  res_valid, res_data, res_rd, res_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Single-outstanding command sequencer with an 8 x 32 register file feeding
//   an external combinational ALU. Commands enter on cmd_*, the ALU is driven
//   for one EXEC cycle, and the captured result leaves on res_*. The result is
//   written back to rf[res_rd] when the result handshake completes.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_op_sequencer_if.slave (cmd_*, alu_*, res_*)
module alu_op_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] rf_q [8];
  logic [31:0] rf_d [8];
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  alu_sel_q, alu_sel_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [31:0] res_data_q, res_data_d;
  logic [2:0]  res_rd_q, res_rd_d;

  logic cmd_ready;
  logic res_valid;
  logic accept;
  logic res_fire;

  // state register and datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      rd_q       <= '0;
      alu_sel_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      rd_q       <= rd_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = bus.cmd_imm_en ? RESP : EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == RESP);
  end

  assign accept   = cmd_ready && bus.cmd_valid;
  assign res_fire = res_valid && bus.res_ready;

  // datapath: operand fetch, result capture, write-back
  always_comb begin
    rf_d       = rf_q;
    rd_d       = rd_q;
    alu_sel_d  = alu_sel_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    if (accept) begin
      rd_d = bus.cmd_rd;
      if (bus.cmd_imm_en) begin
        res_data_d = bus.cmd_imm;
        res_rd_d   = bus.cmd_rd;
      end else begin
        // ALU drive registers only move for ALU commands, so they hold their
        // last values through immediate loads.
        alu_sel_d = bus.cmd_op;
        alu_a_d   = rf_q[bus.cmd_ra];
        alu_b_d   = rf_q[bus.cmd_rb];
      end
    end
    if (state_q == EXEC) begin
      res_data_d = bus.alu_out;
      // res_rd tracks res_data so both change together at capture
      res_rd_d   = rd_q;
    end
    if (res_fire) rf_d[res_rd_q] = res_data_q;
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_zero  = (res_data_q == 32'd0);
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a ^ b;
      3'd3: return a | b;
      3'd4: return a - 32'd1;
      3'd5: return a + b;
      3'd6: return a - b;
      default: return a + 32'd1;
    endcase
  endfunction

  // external combinational ALU
  always_comb bus.alu_out = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction: m_pend says one is in flight, m_lat says it
  // is still waiting on the ALU. Shown result (m_data/m_rd) changes only when
  // the result becomes visible.
  logic [31:0] rf_m [8];
  bit          m_pend, m_lat;
  logic [31:0] m_data, m_nxt_data, m_a, m_b;
  logic [2:0]  m_rd, m_nxt_rd, m_sel;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_lat <= 1'b0;
      m_data <= '0; m_rd <= '0; m_sel <= '0; m_a <= '0; m_b <= '0;
      m_nxt_data <= '0; m_nxt_rd <= '0;
      for (int i = 0; i < 8; i++) rf_m[i] <= '0;
    end else if (!m_pend) begin
      if (bus.cmd_valid) begin
        m_pend <= 1'b1;
        if (bus.cmd_imm_en) begin
          m_lat  <= 1'b0;
          m_data <= bus.cmd_imm;
          m_rd   <= bus.cmd_rd;
        end else begin
          m_lat      <= 1'b1;
          m_sel      <= bus.cmd_op;
          m_a        <= rf_m[bus.cmd_ra];
          m_b        <= rf_m[bus.cmd_rb];
          m_nxt_data <= alu_f(bus.cmd_op, rf_m[bus.cmd_ra], rf_m[bus.cmd_rb]);
          m_nxt_rd   <= bus.cmd_rd;
        end
      end
    end else if (m_lat) begin
      m_lat  <= 1'b0;
      m_data <= m_nxt_data;
      m_rd   <= m_nxt_rd;
    end else if (bus.res_ready) begin
      rf_m[m_rd] <= m_data;
      m_pend     <= 1'b0;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !m_pend});
      cmp("res_valid", {31'd0, bus.res_valid}, {31'd0, m_pend && !m_lat});
      cmp("res_data",  bus.res_data, m_data);
      cmp("res_rd",    {29'd0, bus.res_rd}, {29'd0, m_rd});
      cmp("res_zero",  {31'd0, bus.res_zero}, {31'd0, m_data == 32'd0});
      cmp("alu_sel",   {29'd0, bus.alu_sel}, {29'd0, m_sel});
      cmp("alu_a",     bus.alu_a, m_a);
      cmp("alu_b",     bus.alu_b, m_b);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at a falling edge after the result
  // handshake. lat = rising edges from accept to first visible res_valid.
  task automatic do_cmd(input logic ie, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [31:0] imm,
                        input int dly, output logic [31:0] data, output logic [2:0] rrd,
                        output int lat);
    bit ok = 1'b0;
    int n;
    data = '0; rrd = '0; lat = 0;
    bus.cmd_valid = 1'b1; bus.cmd_imm_en = ie; bus.cmd_op = op;
    bus.cmd_rd = rd; bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_imm = imm;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: cmd_ready stuck 0, want 1");
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus.res_valid) begin
      total++; bad++;
      $display("FAIL result_timeout: res_valid stuck 0, want 1");
      return;
    end
    lat = n; data = bus.res_data; rrd = bus.res_rd;
    repeat (dly) @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic [2:0]  r;
  int          l;
  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'hEDCBA987; sweep_exp[1] = 32'h02244220;
    sweep_exp[2] = 32'h95511559; sweep_exp[3] = 32'h97755779;
    sweep_exp[4] = 32'h12345677; sweep_exp[5] = 32'h99999999;
    sweep_exp[6] = 32'h8ACF1357; sweep_exp[7] = 32'h12345679;

    bus.cmd_valid = 0; bus.cmd_imm_en = 0; bus.cmd_op = 0; bus.cmd_rd = 0;
    bus.cmd_ra = 0; bus.cmd_rb = 0; bus.cmd_imm = 0; bus.res_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cmp("reset_res_zero", {31'd0, bus.res_zero}, 32'd1);
    cmp("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // load and ADD
    do_cmd(1, 0, 1, 0, 0, 32'h12345678, 0, d, r, l);
    cmp("imm_latency", l, 1);
    do_cmd(1, 0, 2, 0, 0, 32'h87654321, 1, d, r, l);
    do_cmd(0, 3'd5, 3, 1, 2, 0, 0, d, r, l);
    cmp("add_data", d, 32'h99999999);
    cmp("add_rd", {29'd0, r}, 32'd3);
    cmp("add_latency", l, 2);

    // op sweep, results into r7 so r1/r2 stay intact
    for (int op = 0; op < 8; op++) begin
      do_cmd(0, op[2:0], 7, 1, 2, 0, op % 3, d, r, l);
      cmp($sformatf("sweep_op%0d", op), d, sweep_exp[op]);
    end

    // wrap and zero flag
    do_cmd(1, 0, 4, 0, 0, 32'hFFFFFFFF, 0, d, r, l);
    do_cmd(0, 3'd7, 5, 4, 0, 0, 0, d, r, l);
    cmp("wrap_data", d, 32'h0);
    cmp("wrap_zero", {31'd0, bus.res_zero}, 32'd1);
    do_cmd(0, 3'd4, 6, 5, 0, 0, 0, d, r, l);
    cmp("dec_wrap", d, 32'hFFFFFFFF);

    // read-after-write, back-to-back
    do_cmd(0, 3'd5, 3, 1, 2, 0, 0, d, r, l);
    do_cmd(0, 3'd5, 6, 3, 3, 0, 0, d, r, l);
    cmp("raw_data", d, 32'h33333332);

    // backpressure with a queued command waiting
    bus.cmd_valid = 1; bus.cmd_imm_en = 0; bus.cmd_op = 3'd1; bus.cmd_rd = 7;
    bus.cmd_ra = 1; bus.cmd_rb = 2;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_imm_en = 1; bus.cmd_rd = 7; bus.cmd_imm = 32'h00005A5A;
    @(negedge clk);
    cmp("bp_valid", {31'd0, bus.res_valid}, 32'd1);
    d = bus.res_data;
    cmp("bp_and", d, 32'h02244220);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("bp_hold_data", bus.res_data, d);
      cmp("bp_hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.res_ready = 1;
    @(negedge clk);
    bus.res_ready = 0;
    cmp("bp_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 0;
    cmp("bp_next_valid", {31'd0, bus.res_valid}, 32'd1);
    cmp("bp_next_data", bus.res_data, 32'h00005A5A);
    bus.res_ready = 1;
    @(negedge clk);
    bus.res_ready = 0;

    // reset during EXEC
    bus.cmd_valid = 1; bus.cmd_imm_en = 0; bus.cmd_op = 3'd5; bus.cmd_rd = 1;
    bus.cmd_ra = 1; bus.cmd_rb = 2;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    cmp("rst_exec_valid", {31'd0, bus.res_valid}, 32'd0);
    cmp("rst_exec_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // reset during RESP (pending write of r1 must be dropped)
    bus.cmd_valid = 1; bus.cmd_imm_en = 1; bus.cmd_rd = 1; bus.cmd_imm = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 0;
    cmp("rst_resp_pre", {31'd0, bus.res_valid}, 32'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    cmp("rst_resp_valid", {31'd0, bus.res_valid}, 32'd0);
    cmp("rst_resp_ready", {31'd0, bus.cmd_ready}, 32'd1);
    cmp("rst_resp_data", bus.res_data, 32'd0);
    do_cmd(0, 3'd5, 2, 1, 2, 0, 0, d, r, l);
    cmp("rst_rf_cleared", d, 32'h0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] im;
      im = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do_cmd(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), im,
             $urandom_range(0, 3), d, r, l);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end
endmodule
